pci_initiator: RTL and testbench

PCI_INITIATOR -- requirements
Module: pci_initiator

---
 rtl/pci_initiator.sv | 242 ++++++++++++++++++++++++
 tb/tb_pci_initiator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_initiator.sv
// PCI bus initiator: one address phase followed by a burst of up to MAX_BURST data
// phases, with target wait states, target disconnect (Stop) and master abort.
module pci_initiator #(
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int MAX_BURST      = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        RdWr,
  input  logic [31:0] Addr,
  input  logic [2:0]  Len,
  input  logic [3:0]  ByteEn,
  input  logic        WrEn,
  input  logic [1:0]  WrIdx,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        RdValid,
  output logic        Busy,
  output logic        Done,
  output logic        Abort,
  output logic        Retry,
  output logic [2:0]  XferCnt,
  output logic        Frame,
  output logic        IRDY,
  output logic [3:0]  Ctrl,
  inout  wire  [31:0] Ad,
  input  logic        DevSel,
  input  logic        TRDY,
  input  logic        Stop
);
  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_TURNOFF} state_t;

  state_t      state_q, state_d;
  logic [31:0] wr_buf_q [MAX_BURST];
  logic [31:0] wr_buf_d [MAX_BURST];
  logic        rd_wr_q, rd_wr_d;
  logic [3:0]  byte_en_q, byte_en_d;
  logic [2:0]  rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d, idx_nxt;
  logic [2:0]  xfer_cnt_q, xfer_cnt_d;
  logic        frame_q, frame_d;
  logic        irdy_q, irdy_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        retry_q, retry_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        dev_seen_q, dev_seen_d;
  logic        stop_pend_q, stop_pend_d;
  logic        abort_pend_q, abort_pend_d;
  logic        retry_pend_q, retry_pend_d;
  logic [2:0]  len_eff;

  always_comb begin
    if (Len == 3'd0)                len_eff = 3'd1;
    else if (int'(Len) > MAX_BURST) len_eff = 3'(MAX_BURST);
    else                            len_eff = Len;
    idx_nxt = (int'(idx_q) == MAX_BURST - 1) ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    wr_buf_d     = wr_buf_q;
    rd_wr_d      = rd_wr_q;
    byte_en_d    = byte_en_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    xfer_cnt_d   = xfer_cnt_q;
    frame_d      = frame_q;
    irdy_d       = irdy_q;
    ctrl_d       = ctrl_q;
    ad_out_d     = ad_out_q;
    ad_oe_d      = ad_oe_q;
    rd_data_d    = rd_data_q;
    busy_d       = busy_q;
    tmo_d        = tmo_q;
    dev_seen_d   = dev_seen_q;
    stop_pend_d  = stop_pend_q;
    abort_pend_d = abort_pend_q;
    retry_pend_d = retry_pend_q;
    rd_valid_d   = 1'b0;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    retry_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (WrEn && int'(WrIdx) < MAX_BURST) wr_buf_d[IW'(WrIdx)] = WrData;
        if (Req) begin
          rd_wr_d      = RdWr;
          byte_en_d    = ByteEn;
          rem_d        = len_eff;
          idx_d        = '0;
          xfer_cnt_d   = 3'd0;
          busy_d       = 1'b1;
          frame_d      = 1'b0;
          irdy_d       = 1'b1;
          ctrl_d       = RdWr ? 4'b0011 : 4'b0010;
          ad_out_d     = Addr;
          ad_oe_d      = 1'b1;
          tmo_d        = 8'(DEVSEL_TIMEOUT);
          dev_seen_d   = 1'b0;
          stop_pend_d  = 1'b0;
          abort_pend_d = 1'b0;
          retry_pend_d = 1'b0;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        irdy_d   = 1'b0;
        ctrl_d   = byte_en_q;
        frame_d  = (rem_q == 3'd1);
        ad_oe_d  = rd_wr_q;
        ad_out_d = wr_buf_q[0];
        state_d  = S_DATA;
      end
      S_DATA: begin
        // Disconnect tail: IRDY was held one extra clock after Stop, now release.
        if (stop_pend_q) begin
          irdy_d  = 1'b1;
          ad_oe_d = 1'b0;
          state_d = S_TURNOFF;
        end else if (!dev_seen_q && DevSel && tmo_q == 8'd1) begin
          frame_d      = 1'b1;
          irdy_d       = 1'b1;
          ad_oe_d      = 1'b0;
          xfer_cnt_d   = 3'd0;
          abort_pend_d = 1'b1;
          state_d      = S_TURNOFF;
        end else begin
          if (!DevSel)          dev_seen_d = 1'b1;
          else if (!dev_seen_q) tmo_d      = tmo_q - 8'd1;
          if (!TRDY) begin
            xfer_cnt_d = xfer_cnt_q + 3'd1;
            idx_d      = idx_nxt;
            rem_d      = rem_q - 3'd1;
            if (!rd_wr_q) begin
              rd_data_d  = Ad;
              rd_valid_d = 1'b1;
            end
          end
          if (!Stop) begin
            stop_pend_d  = 1'b1;
            retry_pend_d = 1'b1;
            frame_d      = 1'b1;
          end else if (!TRDY) begin
            if (rem_q == 3'd1) begin
              frame_d = 1'b1;
              irdy_d  = 1'b1;
              ad_oe_d = 1'b0;
              state_d = S_TURNOFF;
            end else begin
              ad_out_d = wr_buf_q[idx_nxt];
              if (rem_q == 3'd2) frame_d = 1'b1;
            end
          end
        end
      end
      S_TURNOFF: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        abort_d = abort_pend_q;
        retry_d = retry_pend_q;
        ctrl_d  = 4'b0000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < MAX_BURST; i++) wr_buf_q[i] <= '0;
      rd_wr_q      <= 1'b0;
      byte_en_q    <= 4'b0000;
      rem_q        <= 3'd0;
      idx_q        <= '0;
      xfer_cnt_q   <= 3'd0;
      frame_q      <= 1'b1;
      irdy_q       <= 1'b1;
      ctrl_q       <= 4'b0000;
      ad_out_q     <= '0;
      ad_oe_q      <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      retry_q      <= 1'b0;
      tmo_q        <= 8'd0;
      dev_seen_q   <= 1'b0;
      stop_pend_q  <= 1'b0;
      abort_pend_q <= 1'b0;
      retry_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_buf_q     <= wr_buf_d;
      rd_wr_q      <= rd_wr_d;
      byte_en_q    <= byte_en_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      xfer_cnt_q   <= xfer_cnt_d;
      frame_q      <= frame_d;
      irdy_q       <= irdy_d;
      ctrl_q       <= ctrl_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      dev_seen_q   <= dev_seen_d;
      stop_pend_q  <= stop_pend_d;
      abort_pend_q <= abort_pend_d;
      retry_pend_q <= retry_pend_d;
    end
  end

  assign Ad      = ad_oe_q ? ad_out_q : 'z;
  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Abort   = abort_q;
  assign Retry   = retry_q;
  assign XferCnt = xfer_cnt_q;
  assign Frame   = frame_q;
  assign IRDY    = irdy_q;
  assign Ctrl    = ctrl_q;

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: a scripted PCI target, a vector table of directed bursts,
// hand sequences for reset corners and randomized bursts checked against a burst model.
module tb_pci_initiator;
  localparam int DT = 5;
  localparam int MB = 4;

  logic        Clk = 1'b0;
  logic        Rst, Req, RdWr, WrEn, DevSel, TRDY, Stop;
  logic [31:0] Addr, WrData, RdData;
  logic [2:0]  Len, XferCnt;
  logic [3:0]  ByteEn, Ctrl;
  logic [1:0]  WrIdx;
  logic        RdValid, Busy, Done, Abort, Retry, Frame, IRDY;
  wire  [31:0] Ad;
  logic [31:0] tb_ad;
  logic        tb_ad_en;

  assign Ad = tb_ad_en ? tb_ad : 'z;
  always #5 Clk = ~Clk;

  pci_initiator #(.DEVSEL_TIMEOUT(DT), .MAX_BURST(MB)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .RdWr(RdWr), .Addr(Addr), .Len(Len),
    .ByteEn(ByteEn), .WrEn(WrEn), .WrIdx(WrIdx), .WrData(WrData),
    .RdData(RdData), .RdValid(RdValid), .Busy(Busy), .Done(Done), .Abort(Abort),
    .Retry(Retry), .XferCnt(XferCnt), .Frame(Frame), .IRDY(IRDY), .Ctrl(Ctrl),
    .Ad(Ad), .DevSel(DevSel), .TRDY(TRDY), .Stop(Stop)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] buf_m [MB];
  logic [31:0] rd_pat [8];

  int          o_dclk, o_toff, o_xfer;
  logic        o_done, o_abort, o_retry;
  logic [31:0] o_rd [$];

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [3:0]  be;
    int          dsel;   // first data clock with DevSel=0, 0 = never
    int          wt;     // TRDY=1 clocks before each phase
    int          stp;    // phase on which Stop=0 (with TRDY=0), 0 = none
    int          x_xfer;
    logic        x_abort;
    logic        x_retry;
    int          x_dclk;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int i, input logic [31:0] d);
    @(negedge Clk);
    WrEn = 1'b1; WrIdx = 2'(i); WrData = d;
    @(negedge Clk);
    WrEn = 1'b0;
    buf_m[i] = d;
  endtask

  // Burst outcome from plain arithmetic: clocks with IRDY=0 and phases done.
  task automatic model(input logic [2:0] len, input int dsel, input int wt, input int stp,
                       output int x, output logic a, output logic r, output int d);
    int eff;
    eff = (len == 3'd0) ? 1 : ((int'(len) > MB) ? MB : int'(len));
    a = 1'b0; r = 1'b0;
    if (dsel == 0 || dsel > DT) begin
      x = 0; a = 1'b1; d = DT;
    end else if (stp >= 1 && stp <= eff) begin
      x = stp; r = 1'b1; d = (dsel - 1) + stp * (wt + 1) + 1;
    end else begin
      x = eff; d = (dsel - 1) + eff * (wt + 1);
    end
  endtask

  task automatic xfer(input logic rw, input logic [31:0] addr, input logic [2:0] len,
                      input logic [3:0] be, input int dsel, input int wt, input int stp,
                      input bit noise);
    int eff, p, wcnt;
    bit tail, fin;
    eff = (len == 3'd0) ? 1 : ((int'(len) > MB) ? MB : int'(len));
    o_rd.delete(); o_dclk = 0; o_toff = 0; o_xfer = 0;
    o_done = 1'b0; o_abort = 1'b0; o_retry = 1'b0;
    p = 0; wcnt = 0; tail = 1'b0; fin = 1'b0;
    @(negedge Clk);
    Req = 1'b1; RdWr = rw; Addr = addr; Len = len; ByteEn = be;
    @(negedge Clk);
    Req = 1'b0;
    chk("addr_frame", 32'(Frame), 32'd0);
    chk("addr_irdy", 32'(IRDY), 32'd1);
    chk("addr_ctrl", 32'(Ctrl), rw ? 32'h3 : 32'h2);
    chk("addr_ad", Ad, addr);
    chk("addr_busy", 32'(Busy), 32'd1);
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      @(negedge Clk);
      if (RdValid) o_rd.push_back(RdData);
      if (!IRDY) begin
        o_dclk++;
        if (tail) begin
          chk("tail_frame", 32'(Frame), 32'd1);
          DevSel = 1'b0; TRDY = 1'b1; Stop = 1'b0; tb_ad_en = 1'b0;
        end else begin
          chk("data_frame", 32'(Frame), 32'(p == eff - 1));
          chk("data_ctrl", 32'(Ctrl), 32'(be));
          chk("ad_oe", 32'(dut.ad_oe_q), 32'(rw));
          if (rw) chk("wr_word", Ad, buf_m[p % MB]);
          if (dsel > 0 && o_dclk >= dsel) begin
            DevSel = 1'b0;
            if (wcnt < wt) begin
              wcnt++; TRDY = 1'b1; Stop = 1'b1; tb_ad_en = 1'b0;
            end else begin
              TRDY = 1'b0; tb_ad = rd_pat[p]; tb_ad_en = !rw;
              tail = (stp == p + 1);
              Stop = !tail;
              p++; wcnt = 0;
            end
          end else begin
            DevSel = 1'b1; TRDY = 1'b1; Stop = 1'b1; tb_ad_en = 1'b0;
          end
        end
      end else begin
        DevSel = 1'b1; TRDY = 1'b1; Stop = 1'b1; tb_ad_en = 1'b0;
        if (Busy && o_dclk > 0) begin
          o_toff++;
          chk("turnoff_frame", 32'(Frame), 32'd1);
        end
        if (!Busy) begin
          fin = 1'b1;
          o_done = Done; o_abort = Abort; o_retry = Retry; o_xfer = int'(XferCnt);
        end
      end
      if (noise && Busy) begin
        Req = 1'($urandom_range(0, 1));
        WrEn = 1'($urandom_range(0, 1));
        WrIdx = 2'($urandom_range(0, 3));
        WrData = $urandom;
      end else begin
        Req = 1'b0; WrEn = 1'b0;
      end
    end
    chk("xfer_bound", 32'(fin), 32'd1);
    @(negedge Clk);
    chk("done_pulse_end", 32'(Done), 32'd0);
  endtask

  task automatic expect_res(input logic rw, input int x, input logic a, input logic r, input int d);
    chk("xfer_cnt", 32'(o_xfer), 32'(x));
    chk("abort", 32'(o_abort), 32'(a));
    chk("retry", 32'(o_retry), 32'(r));
    chk("done", 32'(o_done), 32'd1);
    chk("data_clks", 32'(o_dclk), 32'(d));
    chk("turnoff_clks", 32'(o_toff), 32'd1);
    chk("rd_count", 32'(o_rd.size()), rw ? 32'd0 : 32'(x));
    for (int i = 0; i < o_rd.size() && i < x; i++) chk("rd_word", o_rd[i], rd_pat[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, d;
    logic a, r;
    logic        rw;
    logic [2:0]  len;
    int dsel, wt, stp;

    vecs[0] = '{1'b1, 32'h00001F40, 3'd4, 4'hF, 2, 0, 0, 4, 1'b0, 1'b0, 5};
    vecs[1] = '{1'b0, 32'h00001F42, 3'd2, 4'hF, 1, 0, 0, 2, 1'b0, 1'b0, 2};
    vecs[2] = '{1'b1, 32'h00002000, 3'd4, 4'hF, 0, 0, 0, 0, 1'b1, 1'b0, 5};
    vecs[3] = '{1'b1, 32'h00003000, 3'd2, 4'hC, 1, 3, 0, 2, 1'b0, 1'b0, 8};
    vecs[4] = '{1'b1, 32'h00004000, 3'd4, 4'hF, 1, 0, 2, 2, 1'b0, 1'b1, 3};
    vecs[5] = '{1'b1, 32'h00005000, 3'd0, 4'h3, 1, 0, 0, 1, 1'b0, 1'b0, 1};
    vecs[6] = '{1'b0, 32'h00006000, 3'd7, 4'hF, 1, 0, 0, 4, 1'b0, 1'b0, 4};
    vecs[7] = '{1'b0, 32'h00007000, 3'd3, 4'h5, 2, 1, 1, 1, 1'b0, 1'b1, 4};
    vecs[8] = '{1'b1, 32'h00008000, 3'd1, 4'hF, 5, 0, 0, 1, 1'b0, 1'b0, 5};
    vecs[9] = '{1'b1, 32'h00009000, 3'd2, 4'hF, 6, 0, 0, 0, 1'b1, 1'b0, 5};

    Rst = 1'b1; Req = 1'b0; RdWr = 1'b0; Addr = '0; Len = '0; ByteEn = '0;
    WrEn = 1'b0; WrIdx = '0; WrData = '0; DevSel = 1'b1; TRDY = 1'b1; Stop = 1'b1;
    tb_ad = '0; tb_ad_en = 1'b0;
    for (int i = 0; i < MB; i++) buf_m[i] = '0;
    #12;
    chk("rst_frame", 32'(Frame), 32'd1);
    chk("rst_irdy", 32'(IRDY), 32'd1);
    chk("rst_ad_oe", 32'(dut.ad_oe_q), 32'd0);
    chk("rst_ctrl", 32'(Ctrl), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_abort", 32'(Abort), 32'd0);
    chk("rst_retry", 32'(Retry), 32'd0);
    chk("rst_rdvalid", 32'(RdValid), 32'd0);
    chk("rst_rddata", RdData, 32'd0);
    chk("rst_xfercnt", 32'(XferCnt), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // Buffer starts cleared, so an unloaded write burst sends zeros.
    xfer(1'b1, 32'h00000100, 3'd4, 4'hF, 1, 0, 0, 1'b0);
    expect_res(1'b1, 4, 1'b0, 1'b0, 4);

    load(0, 32'h11111111);
    load(1, 32'h01000110);
    load(2, 32'h11110000);
    load(3, 32'h0000FFFF);
    rd_pat[0] = 32'hAAAA5555;
    rd_pat[1] = 32'h12345678;
    for (int i = 2; i < 8; i++) rd_pat[i] = 32'hC0DE0000 + 32'(i);

    for (int v = 0; v < 10; v++) begin
      xfer(vecs[v].rw, vecs[v].addr, vecs[v].len, vecs[v].be,
           vecs[v].dsel, vecs[v].wt, vecs[v].stp, 1'b0);
      expect_res(vecs[v].rw, vecs[v].x_xfer, vecs[v].x_abort, vecs[v].x_retry, vecs[v].x_dclk);
    end

    // Reset asserted during the third data phase of a write burst.
    @(negedge Clk);
    Req = 1'b1; RdWr = 1'b1; Addr = 32'h0000A000; Len = 3'd4; ByteEn = 4'hF;
    @(negedge Clk);
    Req = 1'b0; DevSel = 1'b0; TRDY = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_pre_irdy", 32'(IRDY), 32'd0);
    chk("mid_pre_word", Ad, buf_m[2]);
    #2 Rst = 1'b1;
    #1;
    chk("mid_rst_frame", 32'(Frame), 32'd1);
    chk("mid_rst_irdy", 32'(IRDY), 32'd1);
    chk("mid_rst_ad_oe", 32'(dut.ad_oe_q), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    DevSel = 1'b1; TRDY = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < MB; i++) buf_m[i] = '0;
    xfer(1'b1, 32'h0000B000, 3'd3, 4'hF, 1, 0, 0, 1'b0);
    expect_res(1'b1, 3, 1'b0, 1'b0, 3);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, MB - 1)), $urandom);
      for (int i = 0; i < 8; i++) rd_pat[i] = $urandom;
      rw   = 1'($urandom_range(0, 1));
      len  = 3'($urandom_range(0, 7));
      dsel = int'($urandom_range(0, 6));
      wt   = int'($urandom_range(0, 2));
      stp  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      model(len, dsel, wt, stp, x, a, r, d);
      xfer(rw, $urandom, len, 4'($urandom_range(0, 15)), dsel, wt, stp, 1'b1);
      expect_res(rw, x, a, r, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
